// File: rtl/alu_seq_shift.sv
// alu_seq_shift: registered logic/shift unit with valid/ready handshakes.
// Logic ops complete in one cycle. Shifts are executed serially, one bit per
// cycle, with carry reporting the last bit shifted out. The result, zero and
// carry are held stable while the consumer applies back-pressure.
module alu_seq_shift #(
  parameter int N  = 9,
  parameter int SW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    op,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  input  logic [SW-1:0] shamt,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  y,
  output logic          zero,
  output logic          carry
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // N widened by one bit so shift amounts can be compared without overflow.
  localparam logic [SW:0] LP_N = (SW+1)'(N);

  state_t         r_state;
  state_t         w_state_nxt;

  logic [N-1:0]   r_work;
  logic [SW-1:0]  r_cnt;
  logic           r_left;

  logic [N-1:0]   r_y;
  logic           r_zero;
  logic           r_carry;

  logic           w_is_shift;
  logic [SW-1:0]  w_amt;
  logic           w_accept;
  logic           w_start_shift;
  logic           w_last;
  logic [N-1:0]   w_imm;
  logic [N-1:0]   w_shifted;
  logic           w_out_bit;

  // Single-cycle result. Shift ops fall through to a, which is exactly the
  // result of a zero-length shift.
  function automatic logic [N-1:0] f_logic(input logic [2:0] f,
                                           input logic [N-1:0] x,
                                           input logic [N-1:0] z);
    logic [N-1:0] r;
    case (f)
      3'b000:  r = x & z;
      3'b001:  r = x | z;
      3'b010:  r = ~(x & z);
      3'b011:  r = ~(x | z);
      3'b100:  r = x ^ z;
      3'b101:  r = ~(x ^ z);
      default: r = x;
    endcase
    return r;
  endfunction

  assign w_is_shift    = op[2] & op[1];
  // Shift amounts of N or more clamp to N: every bit of a gets shifted out.
  assign w_amt         = ({1'b0, shamt} >= LP_N) ? LP_N[SW-1:0] : shamt;
  assign w_accept      = in_valid && (r_state == IDLE);
  assign w_start_shift = w_accept && w_is_shift && (w_amt != '0);
  assign w_last        = (r_state == SHIFT) && (r_cnt <= SW'(1));
  assign w_imm         = f_logic(op, a, b);

  assign w_shifted = r_left ? {r_work[N-2:0], 1'b0} : {1'b0, r_work[N-1:1]};
  assign w_out_bit = r_left ? r_work[N-1] : r_work[0];

  assign y     = r_y;
  assign zero  = r_zero;
  assign carry = r_carry;

  // State register; reset discards any request in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and handshake outputs decoded from the current state.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_nxt = (w_is_shift && (w_amt != '0)) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (r_cnt <= SW'(1)) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Serial shifter: capture a at acceptance, then move one bit per cycle.
  always_ff @(posedge clk) begin
    if (w_start_shift) begin
      r_work <= a;
      r_cnt  <= w_amt;
      r_left <= ~op[0];
    end else if (r_state == SHIFT) begin
      r_work <= w_shifted;
      r_cnt  <= r_cnt - SW'(1);
    end
  end

  // Result and flags; zero is always written together with y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y     <= '0;
      r_zero  <= 1'b1;
      r_carry <= 1'b0;
    end else if (w_accept && !w_start_shift) begin
      r_y     <= w_imm;
      r_zero  <= (w_imm == '0);
      r_carry <= 1'b0;
    end else if (w_start_shift) begin
      r_carry <= 1'b0;
    end else if (r_state == SHIFT) begin
      r_carry <= w_out_bit;
      if (w_last) begin
        r_y    <= w_shifted;
        r_zero <= (w_shifted == '0);
      end
    end
  end

endmodule
